// File: rtl/lukevassallo_xor_cipher.sv
// ----------------------------------------------------------------------------
// lukevassallo_xor_cipher
//   Tiny-tile stream cipher. A 32-bit maximal-length LFSR
//   (x^32+x^22+x^2+x+1) supplies a keystream bit ks = S[31]. Plaintext is
//   XORed with ks to give ciphertext e; ciphertext is XORed with a
//   one-cycle-delayed ks to recover plaintext d. The LFSR seed is loaded
//   through a daisy-chainable serial config shift register. A free-running
//   counter MSB provides a heartbeat.
//
// Ports
//   io_in[0]    clk      rising-edge clock
//   io_in[1]    rst_n    asynchronous active-low reset
//   io_in[2]    cfg_en   1 = shift config register, LFSR frozen
//   io_in[3]    cfg_i    serial config data in (LSB first)
//   io_in[4]    pt_i     plaintext bit
//   io_in[5]    ct_i     ciphertext bit to decrypt
//   io_in[7:6]  unused
//   io_out[0]   e        registered ciphertext
//   io_out[1]   d        registered decrypted bit
//   io_out[2]   cfg_o    serial config out (config register bit 0)
//   io_out[3]   heartbeat
//   io_out[7:4] tied 0
// ----------------------------------------------------------------------------
module lukevassallo_xor_cipher #(
  parameter logic [31:0] SEED    = 32'hACE1ACE1,
  parameter int unsigned HB_BITS = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned LFSR_W = 32;

  // Pin unpacking
  logic clk;
  logic rst_n;
  logic cfg_en;
  logic cfg_i;
  logic pt_i;
  logic ct_i;
  logic unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign cfg_en    = io_in[2];
  assign cfg_i     = io_in[3];
  assign pt_i      = io_in[4];
  assign ct_i      = io_in[5];
  assign unused_io = ^io_in[7:6];

  // State
  logic [LFSR_W-1:0]  s_q;
  logic [LFSR_W-1:0]  s_d;
  logic [LFSR_W-1:0]  cfg_q;
  logic [LFSR_W-1:0]  cfg_d;
  logic               cfg_en_q;
  logic               ks_d1_q;
  logic               e_q;
  logic               d_q;
  logic [HB_BITS-1:0] hb_q;
  logic [HB_BITS-1:0] hb_d;

  logic ks;
  logic fb;

  assign ks = s_q[LFSR_W-1];
  assign fb = s_q[31] ^ s_q[21] ^ s_q[1] ^ s_q[0];

  // LFSR / config next state: shift config while cfg_en, load on its falling
  // edge (zero seed replaced by SEED so the LFSR never locks up), else step.
  always_comb begin
    s_d   = {s_q[LFSR_W-2:0], fb};
    cfg_d = cfg_q;
    if (cfg_en) begin
      cfg_d = {cfg_i, cfg_q[LFSR_W-1:1]};
      s_d   = s_q;
    end else if (cfg_en_q) begin
      s_d = (cfg_q == '0) ? SEED : cfg_q;
    end
  end

  // Heartbeat counter next state, wraps naturally
  always_comb begin
    hb_d = hb_q + HB_BITS'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= SEED;
      cfg_q    <= '0;
      cfg_en_q <= 1'b0;
      ks_d1_q  <= 1'b0;
      e_q      <= 1'b0;
      d_q      <= 1'b0;
      hb_q     <= '0;
    end else begin
      s_q      <= s_d;
      cfg_q    <= cfg_d;
      cfg_en_q <= cfg_en;
      ks_d1_q  <= ks;
      e_q      <= pt_i ^ ks;
      d_q      <= ct_i ^ ks_d1_q;
      hb_q     <= hb_d;
    end
  end

  assign io_out = {4'b0000, hb_q[HB_BITS-1], cfg_q[0], d_q, e_q};

endmodule

// File: tb/tb_lukevassallo_xor_cipher.sv
// ----------------------------------------------------------------------------
// tb_lukevassallo_xor_cipher
//   Scoreboard bench: the driver applies one input vector per cycle and
//   pushes the expected outputs; a monitor pops and compares after each
//   rising edge (or immediately, for asynchronous reset checks).
// ----------------------------------------------------------------------------
module tb_lukevassallo_xor_cipher;

  localparam logic [31:0] SEED = 32'hACE1ACE1;
  localparam logic [31:0] TAPS = 32'h8020_0003;  // bits 31, 21, 1, 0

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       cfg_en    = 1'b0;
  logic       cfg_i     = 1'b0;
  logic       pt_i      = 1'b0;
  logic       loop_mode = 1'b0;
  logic       ct_i;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign ct_i  = loop_mode ? io_out[0] : 1'b0;
  assign io_in = {2'b00, ct_i, pt_i, cfg_i, cfg_en, rst_n, clk};

  lukevassallo_xor_cipher #(
    .SEED   (SEED),
    .HB_BITS(8)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic       d;
    logic       c;
    logic       h;
    logic [3:0] mask;  // {h, c, d, e} check enables
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event ev_sample;

  // Reference model state
  logic [31:0] m_s;
  logic [31:0] m_cfg;
  logic        m_cfgq;
  logic        m_ks1;
  logic [7:0]  m_hb;

  function automatic void chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or ev_sample);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        if (x.mask[0]) chk({x.name, "_e"},  io_out[0], x.e);
        if (x.mask[1]) chk({x.name, "_d"},  io_out[1], x.d);
        if (x.mask[2]) chk({x.name, "_cfg_o"}, io_out[2], x.c);
        if (x.mask[3]) chk({x.name, "_hb"}, io_out[3], x.h);
        chk4({x.name, "_hi"}, io_out[7:4], 4'b0000);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_s    = SEED;
    m_cfg  = 32'd0;
    m_cfgq = 1'b0;
    m_ks1  = 1'b0;
    m_hb   = 8'd0;
  endtask

  // Called just after a falling edge: applies inputs for the next rising
  // edge, pushes the outputs expected after it, then waits a full cycle.
  // A hand value >= 0 overrides the model for that output.
  task automatic cycle(input logic en, input logic ci, input logic pt,
                       input int e_h, input int d_h, input int c_h,
                       input logic [3:0] mask, input string name);
    exp_t x;
    logic ks;
    cfg_en = en;
    cfg_i  = ci;
    pt_i   = pt;
    ks     = m_s[31];
    x.e    = (e_h < 0) ? (pt ^ ks) : e_h[0];
    x.d    = (d_h < 0) ? m_ks1 : d_h[0];  // ct_i is 0 outside loopback
    m_ks1  = ks;
    if (en)          m_cfg = {ci, m_cfg[31:1]};
    else if (m_cfgq) m_s   = (m_cfg == 32'd0) ? SEED : m_cfg;
    else             m_s   = {m_s[30:0], ^(m_s & TAPS)};
    m_cfgq = en;
    m_hb   = m_hb + 8'd1;
    x.c    = (c_h < 0) ? m_cfg[0] : c_h[0];
    x.h    = m_hb[7];
    x.mask = mask;
    x.name = name;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  // Push an all-zero expectation and sample it right away (no clock edge)
  task automatic expect_zero_now(input string name);
    exp_t x;
    x.e = 1'b0; x.d = 1'b0; x.c = 1'b0; x.h = 1'b0;
    x.mask = 4'hF;
    x.name = name;
    sb_q.push_back(x);
    -> ev_sample;
  endtask

  // Called just after a falling edge; returns just after a falling edge
  task automatic do_reset(input string name);
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    pt_i   = 1'b0;
    model_reset();
    expect_zero_now({name, "_assert"});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_zero_now({name, "_release"});
  endtask

  initial begin
    logic [7:0]  e_ref;
    logic [7:0]  d_ref;
    logic [31:0] pat;
    logic [31:0] one;
    logic        hist[$];
    int          rb;

    e_ref = 8'b1010_1100;
    d_ref = 8'b0101_0110;
    pat   = 32'hDEADBEEF;
    one   = 32'h0000_0001;

    @(negedge clk);
    do_reset("por");

    // Free run 256 cycles from reset; first 8 e/d bits hand-derived from SEED
    for (int k = 0; k < 256; k++)
      cycle(1'b0, 1'b0, 1'b0,
            (k < 8) ? int'(e_ref[7-k]) : -1,
            (k < 8) ? int'(d_ref[7-k]) : -1,
            -1, 4'hF, $sformatf("run%0d", k));

    // Loopback: d observed after edge k equals the plaintext of edge k-1
    loop_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rb = int'($urandom_range(0, 1));
      cycle(1'b0, 1'b0, rb[0], -1,
            (k >= 1) ? int'(hist[k-1]) : -1, -1,
            (k >= 1) ? 4'hF : 4'hD, $sformatf("loop%0d", k));
      hist.push_back(rb[0]);
    end
    loop_mode = 1'b0;

    // Fill config with a pattern, then shift in 1; cfg_o replays the pattern
    for (int k = 0; k < 32; k++)
      cycle(1'b1, pat[k], 1'b0, -1, -1, -1, 4'hF, $sformatf("shpat%0d", k));
    for (int k = 0; k < 32; k++)
      cycle(1'b1, one[k], 1'b0, -1, -1,
            (k < 31) ? int'(pat[k+1]) : 1, 4'hF, $sformatf("shone%0d", k));
    cycle(1'b0, 1'b0, 1'b0, -1, -1, -1, 4'hF, "load_one");
    // S = 1: the single set bit reaches bit 31 after 31 steps
    for (int j = 0; j < 32; j++)
      cycle(1'b0, 1'b0, 1'b0, (j == 31) ? 1 : 0, -1, -1, 4'hF, $sformatf("ks_one%0d", j));
    for (int j = 0; j < 40; j++)
      cycle(1'b0, 1'b0, 1'b0, -1, -1, -1, 4'hF, $sformatf("ks_mdl%0d", j));

    // All-zero config load falls back to SEED
    for (int k = 0; k < 32; k++)
      cycle(1'b1, 1'b0, 1'b0, -1, -1, -1, 4'hF, $sformatf("shzero%0d", k));
    cycle(1'b0, 1'b0, 1'b0, -1, -1, -1, 4'hF, "load_zero");
    for (int j = 0; j < 8; j++)
      cycle(1'b0, 1'b0, 1'b0, int'(e_ref[7-j]), -1, -1, 4'hF, $sformatf("ks_seed%0d", j));

    // Reset in the middle of a config shift
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 1'b1, 1'b0, -1, -1, -1, 4'hF, $sformatf("shten%0d", k));
    do_reset("midcfg");
    for (int j = 0; j < 8; j++)
      cycle(1'b0, 1'b0, 1'b0, int'(e_ref[7-j]), int'(d_ref[7-j]), 0, 4'hF,
            $sformatf("post_rst%0d", j));

    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
